// File: rtl/dsp_load_sequencer.sv
// DSP load sequencer: ramps column enables, then toggle rate, up and down.
// Optional activity monitor on act_cnt: define DSP_LOAD_SEQ_ACT_MON_EN.
module dsp_load_sequencer #(
  parameter int NUM_DSP_COLUMN = 5,
  parameter int DWELL_CYCLES   = 1024,
  parameter int RATE_STEP      = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stop,
  input  logic [6:0]                target_rate,
  input  logic                      dsp_top_o,
  output logic                      dsp_rst,
  output logic [NUM_DSP_COLUMN-1:0] col_en,
  output logic [6:0]                TOGGLE_RATE,
  output logic                      busy,
  output logic                      at_target,
  output logic [15:0]               act_cnt
);

  localparam int DCW =
    (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DCW-1:0] DWELL_LAST =
    DCW'(DWELL_CYCLES - 1);
  localparam logic [DCW-1:0] DWELL_ONE = DCW'(1);
  localparam logic [7:0] STEP8 = 8'(RATE_STEP);
  localparam logic [6:0] STEP7 = 7'(RATE_STEP);
  localparam logic [6:0] MAX_RATE = 7'd100;
  localparam logic [NUM_DSP_COLUMN-1:0] COL_ALL = '1;
  localparam logic [NUM_DSP_COLUMN-1:0] COL_ONE =
    NUM_DSP_COLUMN'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COL_UP,
    S_RATE_UP,
    S_HOLD,
    S_RATE_DOWN,
    S_COL_DOWN
  } state_t;

  state_t                    r_state;
  logic [NUM_DSP_COLUMN-1:0] r_col;
  logic [6:0]                r_rate;
  logic [DCW-1:0]            r_dwell;
  logic                      r_stopping;
  logic                      r_busy;
  logic                      r_at;
  logic                      r_dsp_rst;

  state_t                    w_state_nx;
  logic [NUM_DSP_COLUMN-1:0] w_col_nx;
  logic [6:0]                w_rate_nx;
  logic [DCW-1:0]            w_dwell_nx;
  logic                      w_stop_nx;
  logic [6:0]                w_tgt;
  logic [6:0]                w_floor;
  logic [7:0]                w_sum;
  logic [6:0]                w_rate_up;
  logic [6:0]                w_rate_dn;
  logic                      w_step;

  // Effective target and the saturating ramp arithmetic.
  always_comb begin
    w_tgt     = (target_rate > MAX_RATE) ? MAX_RATE : target_rate;
    w_floor   = r_stopping ? 7'd0 : w_tgt;
    w_sum     = {1'b0, r_rate} + STEP8;
    w_rate_up = (w_sum > {1'b0, w_tgt}) ? w_tgt : w_sum[6:0];
    w_rate_dn = ({1'b0, r_rate} > ({1'b0, w_floor} + STEP8)) ?
                (r_rate - STEP7) : w_floor;
    w_step    = (r_dwell == DWELL_LAST);
  end

  // Next-state and next-output decode.
  always_comb begin
    w_state_nx = r_state;
    w_col_nx   = r_col;
    w_rate_nx  = r_rate;
    w_stop_nx  = r_stopping;
    w_dwell_nx = w_step ? '0 : r_dwell + DWELL_ONE;
    unique case (r_state)
      S_IDLE: begin
        w_dwell_nx = '0;
        if (start && !stop) begin
          w_state_nx = S_COL_UP;
          w_col_nx   = COL_ONE;
          w_rate_nx  = 7'd0;
          w_stop_nx  = 1'b0;
        end
      end
      S_COL_UP: begin
        if (stop) begin
          w_state_nx = S_RATE_DOWN;
          w_stop_nx  = 1'b1;
          w_dwell_nx = '0;
        end else if (w_step) begin
          if (r_col == COL_ALL) begin
            w_state_nx = S_RATE_UP;
            w_rate_nx  = w_rate_up;
          end else begin
            w_col_nx = (r_col << 1) | COL_ONE;
          end
        end
      end
      S_RATE_UP: begin
        if (stop) begin
          w_state_nx = S_RATE_DOWN;
          w_stop_nx  = 1'b1;
          w_dwell_nx = '0;
        end else if (w_step) begin
          if (r_rate == w_tgt) w_state_nx = S_HOLD;
          else                 w_rate_nx  = w_rate_up;
        end
      end
      S_HOLD: begin
        w_dwell_nx = '0;
        if (stop) begin
          w_state_nx = S_RATE_DOWN;
          w_stop_nx  = 1'b1;
        end else if (w_tgt > r_rate) begin
          w_state_nx = S_RATE_UP;
        end else if (w_tgt < r_rate) begin
          w_state_nx = S_RATE_DOWN;
          w_stop_nx  = 1'b0;
        end
      end
      S_RATE_DOWN: begin
        if (stop) begin
          w_stop_nx  = 1'b1;
          w_dwell_nx = '0;
        end else if (w_step) begin
          if (r_rate == w_floor)
            w_state_nx = r_stopping ? S_COL_DOWN : S_HOLD;
          else
            w_rate_nx = w_rate_dn;
        end
      end
      S_COL_DOWN: begin
        if (w_step) begin
          w_col_nx = r_col >> 1;
          if ((r_col >> 1) == '0) w_state_nx = S_IDLE;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_dwell_nx = '0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_col      <= '0;
      r_rate     <= 7'd0;
      r_dwell    <= '0;
      r_stopping <= 1'b0;
      r_busy     <= 1'b0;
      r_at       <= 1'b0;
      r_dsp_rst  <= 1'b1;
    end else begin
      r_state    <= w_state_nx;
      r_col      <= w_col_nx;
      r_rate     <= w_rate_nx;
      r_dwell    <= w_dwell_nx;
      r_stopping <= w_stop_nx;
      r_busy     <= (w_state_nx != S_IDLE);
      r_at       <= (w_state_nx == S_HOLD);
      r_dsp_rst  <= (w_state_nx == S_IDLE);
    end
  end

  assign dsp_rst     = r_dsp_rst;
  assign col_en      = r_col;
  assign TOGGLE_RATE = r_rate;
  assign busy        = r_busy;
  assign at_target   = r_at;

`ifdef DSP_LOAD_SEQ_ACT_MON_EN
  logic        r_prev;
  logic [15:0] r_win;
  logic [15:0] r_tcnt;
  logic [15:0] r_act;
  logic        w_edge;
  logic [15:0] w_tnx;

  // Saturating transition count including this cycle's edge.
  always_comb begin
    w_edge = dsp_top_o ^ r_prev;
    w_tnx  = (r_tcnt == 16'hFFFF) ? r_tcnt : r_tcnt + 16'(w_edge);
  end

  // 65536-cycle window; publish the count at each window end.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= 1'b0;
      r_win  <= '0;
      r_tcnt <= '0;
      r_act  <= '0;
    end else begin
      r_prev <= dsp_top_o;
      r_win  <= r_win + 16'd1;
      if (r_win == 16'hFFFF) begin
        r_act  <= w_tnx;
        r_tcnt <= '0;
      end else begin
        r_tcnt <= w_tnx;
      end
    end
  end

  assign act_cnt = r_act;
`else
  logic w_unused;
  assign w_unused = dsp_top_o;
  assign act_cnt  = 16'd0;
`endif

endmodule

// File: doc/dsp_load_sequencer.md
DSP_LOAD_SEQUENCER -- requirements
Module: dsp_load_sequencer

Interface
REQ-001 SHALL have parameter NUM_DSP_COLUMN, default 5: number of DSP columns controlled.
REQ-002 SHALL have parameter DWELL_CYCLES, default 1024: clk cycles between ramp steps, minimum 2.
REQ-003 SHALL have parameter RATE_STEP, default 10: toggle-rate increment/decrement per step, range 1..100.
REQ-004 SHALL have port: clk  in  1  sole clock.
REQ-005 SHALL have port: rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port: start  in  1  one-cycle request to ramp up.
REQ-007 SHALL have port: stop  in  1  one-cycle request to ramp down.
REQ-008 SHALL have port: target_rate  in  7  requested toggle rate, percent.
REQ-009 SHALL have port: dsp_top_o  in  1  XOR-reduced output of the DSP array.
REQ-010 SHALL have port: dsp_rst  out  1  reset to the DSP array.
REQ-011 SHALL have port: col_en  out  NUM_DSP_COLUMN  thermometer column enables, bit 0 first.
REQ-012 SHALL have port: TOGGLE_RATE  out  7  toggle rate driven to the array.
REQ-013 SHALL have port: busy  out  1  high in any state other than IDLE.
REQ-014 SHALL have port: at_target  out  1  high only in HOLD.
REQ-015 SHALL have port: act_cnt  out  16  activity count (see Configuration).

Function
REQ-016 SHALL implement states IDLE, COL_UP, RATE_UP, HOLD, RATE_DOWN, COL_DOWN.
REQ-017 SHALL clamp target_rate >100 to 100; the clamped value is the effective target, sampled every cycle.
REQ-018 SHALL, in IDLE on start, enter COL_UP next cycle with col_en=1, TOGGLE_RATE=0, dwell counter=0.
REQ-019 SHALL run the dwell counter 0..DWELL_CYCLES-1 in every state except IDLE and HOLD; a step occurs when it equals DWELL_CYCLES-1, after which it returns to 0.
REQ-020 SHALL, in COL_UP at a step, shift one more 1 into col_en; if col_en is already all ones, go to RATE_UP and apply the first rate step in the same cycle.
REQ-021 SHALL, at a RATE_UP step, go to HOLD if TOGGLE_RATE equals the target, else set TOGGLE_RATE=min(TOGGLE_RATE+RATE_STEP, target).
REQ-022 SHALL, in HOLD, go to RATE_UP (target above TOGGLE_RATE) or RATE_DOWN (target below TOGGLE_RATE) next cycle with dwell counter=0.
REQ-023 SHALL, at a RATE_DOWN step, set TOGGLE_RATE=max(TOGGLE_RATE-RATE_STEP, floor); on a step where TOGGLE_RATE already equals floor, go to HOLD (floor=target) or COL_DOWN (floor=0 when stopping).
REQ-024 SHALL, on stop in COL_UP, RATE_UP, HOLD or RATE_DOWN, go to RATE_DOWN with floor 0 next cycle, dwell counter=0; a later start is ignored until IDLE.
REQ-025 SHALL, at a COL_DOWN step, clear the highest set bit of col_en; when col_en becomes 0, go to IDLE.
REQ-026 SHALL give stop priority over start when both are asserted in the same cycle; start when not in IDLE and stop in IDLE or COL_DOWN SHALL be ignored.
REQ-027 SHALL assert dsp_rst in IDLE and deassert it from the first cycle in COL_UP.
REQ-028 SHALL drive all outputs from registers.

Reset
REQ-029 SHALL, on rst, force IDLE, col_en=0, TOGGLE_RATE=0, busy=0, at_target=0, dsp_rst=1, act_cnt=0 and dwell counter=0 on the next edge, from any state including mid-ramp.

Configuration
REQ-030 SHALL, with macro DSP_LOAD_SEQ_ACT_MON_EN defined, count dsp_top_o transitions (either edge) in consecutive 65536-cycle windows, saturating at 16'hFFFF, and load act_cnt at each window end; the window restarts on rst.
REQ-031 SHALL, without DSP_LOAD_SEQ_ACT_MON_EN, keep the act_cnt port and tie it to 0 with no monitor logic.

Verification (NUM_DSP_COLUMN=5, DWELL_CYCLES=4, RATE_STEP=10)
REQ-032 SHALL cover: start at cycle 0 with target 25 -> col_en=00001 @1, 11111 @17; TOGGLE_RATE=10 @21, 20 @25, 25 @29; HOLD with at_target=1 @33.
REQ-033 SHALL cover: in HOLD at 25, target changed to 5 -> RATE_DOWN: TOGGLE_RATE 15, 5 at successive steps, then HOLD.
REQ-034 SHALL cover: stop in HOLD at 25 -> TOGGLE_RATE 15, 5, 0 then COL_DOWN col_en 01111..00000 every 4 cycles -> IDLE, dsp_rst=1, busy=0.
REQ-035 SHALL cover: start and stop asserted in the same IDLE cycle -> stays IDLE; target 120 -> ramp saturates at 100.
REQ-036 SHALL cover: rst during RATE_UP -> next cycle all outputs at reset values; subsequent start ramps normally from col_en=00001.
REQ-037 SHALL cover: with DSP_LOAD_SEQ_ACT_MON_EN, dsp_top_o toggling every cycle -> act_cnt=65535 after first window; without the macro act_cnt=0 always.
